// File: rtl/aes_job_arbiter_if.sv
// Bundle of request, core-side and response signals around the shared AES job arbiter.
// The master modport is the arbiter's view; slave is the view of the surrounding sources/core/sink.
`timescale 1ns/1ps
interface aes_job_arbiter_if #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
);
    logic [NREQ-1:0]        req_valid;
    logic [NREQ-1:0]        req_ready;
    logic [NREQ-1:0][1:0]   req_func;
    logic [NREQ-1:0][127:0] req_text;
    logic [NREQ-1:0][127:0] req_key;

    logic                   core_start;
    logic [1:0]             core_func;
    logic [127:0]           core_text;
    logic [127:0]           core_key;
    logic                   core_done;
    logic [127:0]           core_ciphertext;
    logic [127:0]           core_plaintext;

    logic                   rsp_valid;
    logic                   rsp_ready;
    logic [IDW-1:0]         rsp_id;
    logic [127:0]           rsp_data;
    logic                   rsp_err;
    logic                   busy;

    modport master (
        input  req_valid, req_func, req_text, req_key,
        input  core_done, core_ciphertext, core_plaintext,
        input  rsp_ready,
        output req_ready,
        output core_start, core_func, core_text, core_key,
        output rsp_valid, rsp_id, rsp_data, rsp_err, busy
    );

    modport slave (
        output req_valid, req_func, req_text, req_key,
        output core_done, core_ciphertext, core_plaintext,
        output rsp_ready,
        input  req_ready,
        input  core_start, core_func, core_text, core_key,
        input  rsp_valid, rsp_id, rsp_data, rsp_err, busy
    );
endinterface

// File: rtl/aes_job_arbiter.sv
// Round-robin arbiter that feeds one AES core from NREQ requesters, one job in flight,
// with a completion timeout and exactly one tagged response per accepted job.
`timescale 1ns/1ps
module aes_job_arbiter #(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 64,
    parameter int IDW     = $clog2(NREQ)
) (
    input  logic              eph1,
    input  logic              reset,
    aes_job_arbiter_if.master bus
);
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;
    localparam int TW = $clog2(TIMEOUT);

    logic [1:0]     state_q, state_d;
    logic [IDW-1:0] ptr_q,   ptr_d;
    logic [IDW-1:0] id_q,    id_d;
    logic [1:0]     func_q,  func_d;
    logic [127:0]   text_q,  text_d;
    logic [127:0]   key_q,   key_d;
    logic [127:0]   data_q,  data_d;
    logic           err_q,   err_d;
    logic [TW-1:0]  timer_q, timer_d;

    logic [NREQ-1:0]          rot_valid;
    logic [NREQ-1:0][IDW-1:0] rot_idx;
    logic                     grant_any;
    logic [IDW-1:0]           grant_id;
    logic [NREQ-1:0]          req_ready;

    // Slot gi of the rotated view is requester (ptr + gi) mod NREQ.
    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_rot
            logic [IDW:0] sum;
            assign sum           = {1'b0, ptr_q} + (IDW+1)'(gi);
            assign rot_idx[gi]   = (sum >= (IDW+1)'(NREQ)) ? IDW'(sum - (IDW+1)'(NREQ))
                                                           : sum[IDW-1:0];
            assign rot_valid[gi] = bus.req_valid[rot_idx[gi]];
        end
    endgenerate

    always_comb begin
        grant_any = 1'b0;
        grant_id  = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (rot_valid[k]) begin
                grant_any = 1'b1;
                grant_id  = rot_idx[k];
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (reset && state_q == ST_IDLE && grant_any) begin
            req_ready[grant_id] = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        id_d    = id_q;
        func_d  = func_q;
        text_d  = text_q;
        key_d   = key_q;
        data_d  = data_q;
        err_d   = err_q;
        timer_d = timer_q;
        case (state_q)
            ST_IDLE: begin
                if (grant_any) begin
                    id_d   = grant_id;
                    func_d = bus.req_func[grant_id];
                    text_d = bus.req_text[grant_id];
                    key_d  = bus.req_key[grant_id];
                    if (bus.req_func[grant_id] == 2'b00) begin
                        err_d   = 1'b1;
                        data_d  = '0;
                        state_d = ST_RESP;
                    end else begin
                        state_d = ST_START;
                    end
                end
            end
            ST_START: begin
                timer_d = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                timer_d = timer_q + 1'b1;
                // A completion in the final timeout cycle still counts as success.
                if (bus.core_done) begin
                    data_d  = func_q[0] ? bus.core_ciphertext : bus.core_plaintext;
                    err_d   = 1'b0;
                    state_d = ST_RESP;
                end else if (timer_q == TW'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    data_d  = '0;
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                if (bus.rsp_ready) begin
                    ptr_d = id_q + 1'b1;
                    if (id_q == IDW'(NREQ - 1)) begin
                        ptr_d = '0;
                    end
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge eph1) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            id_q    <= '0;
            func_q  <= '0;
            text_q  <= '0;
            key_q   <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            id_q    <= id_d;
            func_q  <= func_d;
            text_q  <= text_d;
            key_q   <= key_d;
            data_q  <= data_d;
            err_q   <= err_d;
            timer_q <= timer_d;
        end
    end

    assign bus.req_ready  = req_ready;
    assign bus.core_start = (state_q == ST_START);
    assign bus.core_func  = func_q;
    assign bus.core_text  = text_q;
    assign bus.core_key   = key_q;
    assign bus.rsp_valid  = (state_q == ST_RESP);
    assign bus.rsp_id     = id_q;
    assign bus.rsp_data   = data_q;
    assign bus.rsp_err    = err_q;
    assign bus.busy       = (state_q != ST_IDLE);
endmodule

// File: tb/tb_aes_job_arbiter.sv
// Directed bench for aes_job_arbiter: the bench acts as requesters, AES core model and response sink.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
`timescale 1ns/1ps
module tb_aes_job_arbiter;
    localparam int NREQ    = 4;
    localparam int TIMEOUT = 8;
    localparam int IDW     = 2;

    localparam logic [127:0] AES_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] AES_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] AES_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] ALL_AA  = {16{8'hAA}};
    localparam logic [127:0] ALL_55  = {16{8'h55}};
    localparam logic [127:0] C1      = 128'hc1c1c1c1_00000000_11111111_22222222;
    localparam logic [127:0] C2      = 128'hc2c2c2c2_33333333_44444444_55555555;

    logic eph1  = 1'b0;
    logic reset = 1'b0;
    int   checks   = 0;
    int   failures = 0;
    int   cyc = 0;
    int   core_delay = -1;
    int   start_cyc = -100;
    int   prev_start_cyc = -100;
    int   start_cnt = 0;
    logic spur_done = 1'b0;

    aes_job_arbiter_if #(.NREQ(NREQ), .IDW(IDW)) bus();

    aes_job_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT), .IDW(IDW)) dut (
        .eph1  (eph1),
        .reset (reset),
        .bus   (bus.master)
    );

    always #5 eph1 = ~eph1;

    always @(posedge eph1) cyc <= cyc + 1;

    always @(negedge eph1) begin
        if (bus.core_start === 1'b1) begin
            start_cnt      <= start_cnt + 1;
            prev_start_cyc <= start_cyc;
            start_cyc      <= cyc;
        end
    end

    // Core model: completion core_delay cycles after the start pulse, plus optional spurious pulses.
    initial begin
        bus.core_done = 1'b0;
        forever begin
            @(posedge eph1);
            #2;
            bus.core_done = spur_done | ((core_delay >= 0) && (cyc == start_cyc + core_delay));
        end
    end

    task automatic to_start();
        @(posedge eph1);
        #1;
    endtask

    task automatic to_mid();
        @(negedge eph1);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        to_mid();
        to_start();
        reset = 1'b1;
    endtask

    task automatic run_job(input int idx, input logic [1:0] func, input int delay,
                           output int lat, output logic [IDW-1:0] id,
                           output logic [127:0] data, output logic err, output bit ok);
        int t0;
        int n;
        bus.req_func[idx]  = func;
        bus.req_valid      = '0;
        bus.req_valid[idx] = 1'b1;
        bus.rsp_ready      = 1'b1;
        core_delay         = delay;
        to_mid();
        t0 = cyc;
        ok = (bus.req_ready[idx] === 1'b1);
        to_start();
        bus.req_valid = '0;
        to_mid();
        n = 0;
        while (bus.rsp_valid !== 1'b1 && n < 40) begin
            to_start();
            to_mid();
            n++;
        end
        lat  = cyc - t0;
        id   = bus.rsp_id;
        data = bus.rsp_data;
        err  = bus.rsp_err;
        ok   = ok && (bus.rsp_valid === 1'b1);
        $display("job req=%0d func=%b lat=%0d id=%0d err=%0d data=%h", idx, func, lat, id, err, data);
        to_start();
    endtask

    task automatic test_reset();
        to_start();
        bus.req_valid = '1;
        to_mid();
        checks++;
        if ({bus.rsp_valid, bus.rsp_id, bus.rsp_data, bus.rsp_err, bus.core_start,
             bus.core_func, bus.core_text, bus.core_key, bus.busy} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: got valid=%b id=%0d err=%b start=%b func=%b busy=%b data=%h expected all zero",
                     bus.rsp_valid, bus.rsp_id, bus.rsp_err, bus.core_start, bus.core_func, bus.busy, bus.rsp_data);
        end
        checks++;
        if (bus.req_ready !== 4'b0000) begin
            failures++;
            $display("FAIL reset_req_ready: got %b expected 0000", bus.req_ready);
        end
        to_start();
        reset = 1'b1;
        bus.req_valid = '0;
    endtask

    task automatic test_single_encrypt();
        int n;
        bus.req_key[0]      = AES_KEY;
        bus.req_text[0]     = AES_PT;
        bus.req_func[0]     = 2'b01;
        bus.core_ciphertext = AES_CT;
        bus.core_plaintext  = '0;
        bus.rsp_ready       = 1'b1;
        core_delay          = 5;
        bus.req_valid       = 4'b0001;
        to_mid();
        checks++;
        if (bus.req_ready !== 4'b0001) begin
            failures++;
            $display("FAIL enc_grant: got %b expected 0001", bus.req_ready);
        end
        to_start();
        bus.req_valid = '0;
        to_mid();
        checks++;
        if (bus.core_start !== 1'b1 || bus.busy !== 1'b1) begin
            failures++;
            $display("FAIL enc_start_t1: got start=%b busy=%b expected 1 1", bus.core_start, bus.busy);
        end
        checks++;
        if (bus.core_func !== 2'b01 || bus.core_key !== AES_KEY || bus.core_text !== AES_PT) begin
            failures++;
            $display("FAIL enc_core_regs: got func=%b key=%h text=%h expected 01 %h %h",
                     bus.core_func, bus.core_key, bus.core_text, AES_KEY, AES_PT);
        end
        n = 0;
        while (bus.rsp_valid !== 1'b1 && n < 40) begin
            to_start();
            to_mid();
            n++;
        end
        checks++;
        if (n !== 6) begin
            failures++;
            $display("FAIL enc_latency: got %0d cycles after start expected 6", n);
        end
        checks++;
        if (bus.rsp_id !== 2'd0 || bus.rsp_err !== 1'b0 || bus.rsp_data !== AES_CT) begin
            failures++;
            $display("FAIL enc_rsp: got id=%0d err=%b data=%h expected 0 0 %h",
                     bus.rsp_id, bus.rsp_err, bus.rsp_data, AES_CT);
        end
        $display("job req=0 func=01 start_to_rsp=%0d data=%h", n, bus.rsp_data);
        to_start();
    endtask

    task automatic test_round_robin();
        int exp_id[9] = '{0, 1, 2, 3, 0, 2, 3, 0, 2};
        logic [NREQ-1:0] grants[9];
        logic [NREQ-1:0] onehot;
        int acc_cyc[9];
        int ng;
        int nr;
        int n;
        do_reset();
        for (int i = 0; i < NREQ; i++) begin
            bus.req_func[i] = 2'b01;
        end
        core_delay    = 1;
        bus.rsp_ready = 1'b1;
        bus.req_valid = '1;
        ng = 0;
        nr = 0;
        n  = 0;
        while (ng < 9 && n < 300) begin
            to_mid();
            if (bus.rsp_valid === 1'b1) begin
                checks++;
                if (nr < 9 && bus.rsp_id !== IDW'(exp_id[nr])) begin
                    failures++;
                    $display("FAIL rr_rsp_id[%0d]: got %0d expected %0d", nr, bus.rsp_id, exp_id[nr]);
                end
                $display("rr rsp #%0d id=%0d", nr, bus.rsp_id);
                nr++;
            end
            if (bus.req_ready !== '0) begin
                grants[ng]  = bus.req_ready;
                acc_cyc[ng] = cyc;
                ng++;
            end
            to_start();
            if (ng >= 5) bus.req_valid = 4'b1101;
            n++;
        end
        checks++;
        if (ng !== 9) begin
            failures++;
            $display("FAIL rr_grant_count: got %0d expected 9", ng);
        end
        for (int k = 0; k < ng; k++) begin
            onehot = '0;
            onehot[exp_id[k]] = 1'b1;
            checks++;
            if (grants[k] !== onehot) begin
                failures++;
                $display("FAIL rr_grant[%0d]: got %b expected %b", k, grants[k], onehot);
            end
        end
        checks++;
        if (acc_cyc[1] - acc_cyc[0] !== 4) begin
            failures++;
            $display("FAIL rr_accept_spacing: got %0d expected 4", acc_cyc[1] - acc_cyc[0]);
        end
        checks++;
        if (start_cyc - prev_start_cyc !== 4) begin
            failures++;
            $display("FAIL rr_start_spacing: got %0d expected 4", start_cyc - prev_start_cyc);
        end
        bus.req_valid = '0;
        n = 0;
        to_mid();
        while (bus.rsp_valid !== 1'b1 && n < 50) begin
            to_start();
            to_mid();
            n++;
        end
        checks++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'd2) begin
            failures++;
            $display("FAIL rr_last_rsp: got valid=%b id=%0d expected 1 2", bus.rsp_valid, bus.rsp_id);
        end
        to_start();
    endtask

    task automatic test_decrypt_select();
        int lat;
        logic [IDW-1:0] id;
        logic [127:0] data;
        logic err;
        bit ok;
        bus.core_plaintext  = ALL_AA;
        bus.core_ciphertext = ALL_55;
        run_job(2, 2'b10, 3, lat, id, data, err, ok);
        checks++;
        if (!ok || data !== ALL_AA || err !== 1'b0 || id !== 2'd2) begin
            failures++;
            $display("FAIL dec_func10: got ok=%0d id=%0d err=%b data=%h expected 1 2 0 %h", ok, id, err, data, ALL_AA);
        end
        run_job(2, 2'b11, 3, lat, id, data, err, ok);
        checks++;
        if (!ok || data !== ALL_55 || err !== 1'b0) begin
            failures++;
            $display("FAIL dec_func11: got ok=%0d err=%b data=%h expected 1 0 %h", ok, err, data, ALL_55);
        end
    endtask

    task automatic test_illegal_timeout();
        int lat;
        logic [IDW-1:0] id;
        logic [127:0] data;
        logic err;
        bit ok;
        int s0;
        bus.core_ciphertext = C1;
        s0 = start_cnt;
        run_job(3, 2'b00, -1, lat, id, data, err, ok);
        checks++;
        if (!ok || lat !== 1 || err !== 1'b1 || data !== '0 || id !== 2'd3) begin
            failures++;
            $display("FAIL illegal_rsp: got ok=%0d lat=%0d id=%0d err=%b data=%h expected 1 1 3 1 0", ok, lat, id, err, data);
        end
        checks++;
        if (start_cnt !== s0) begin
            failures++;
            $display("FAIL illegal_no_start: got %0d starts expected 0", start_cnt - s0);
        end
        run_job(0, 2'b01, -1, lat, id, data, err, ok);
        checks++;
        if (!ok || lat !== TIMEOUT + 2 || err !== 1'b1 || data !== '0) begin
            failures++;
            $display("FAIL timeout_rsp: got ok=%0d lat=%0d err=%b data=%h expected 1 10 1 0", ok, lat, err, data);
        end
        run_job(0, 2'b01, TIMEOUT, lat, id, data, err, ok);
        checks++;
        if (!ok || lat !== TIMEOUT + 2 || err !== 1'b0 || data !== C1) begin
            failures++;
            $display("FAIL done_on_timeout: got ok=%0d lat=%0d err=%b data=%h expected 1 10 0 %h", ok, lat, err, data, C1);
        end
    endtask

    task automatic test_backpressure();
        int n;
        int s0;
        int hs_cyc;
        for (int i = 0; i < NREQ; i++) begin
            bus.req_func[i] = 2'b01;
        end
        bus.core_ciphertext = C1;
        bus.rsp_ready       = 1'b0;
        core_delay          = 2;
        bus.req_valid       = 4'b0010;
        to_mid();
        to_start();
        bus.req_valid = '1;
        to_mid();
        n = 0;
        while (bus.rsp_valid !== 1'b1 && n < 40) begin
            to_start();
            to_mid();
            n++;
        end
        to_start();
        s0 = start_cnt;
        bus.core_ciphertext = C2;
        for (int i = 0; i < 20; i++) begin
            if (i > 0) to_start();
            spur_done = (i == 5);
            to_mid();
            checks++;
            if ({bus.rsp_valid, bus.rsp_id, bus.rsp_err, bus.req_ready, bus.busy} !== {1'b1, 2'd1, 1'b0, 4'b0000, 1'b1}
                || bus.rsp_data !== C1) begin
                failures++;
                $display("FAIL bp_hold[%0d]: got valid=%b id=%0d err=%b ready=%b busy=%b data=%h expected 1 1 0 0000 1 %h",
                         i, bus.rsp_valid, bus.rsp_id, bus.rsp_err, bus.req_ready, bus.busy, bus.rsp_data, C1);
            end
        end
        to_start();
        spur_done     = 1'b0;
        bus.rsp_ready = 1'b1;
        checks++;
        if (start_cnt !== s0) begin
            failures++;
            $display("FAIL bp_no_start: got %0d extra starts expected 0", start_cnt - s0);
        end
        to_mid();
        hs_cyc = cyc;
        checks++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== C1) begin
            failures++;
            $display("FAIL bp_release: got valid=%b data=%h expected 1 %h", bus.rsp_valid, bus.rsp_data, C1);
        end
        $display("bp handshake id=%0d data=%h at cycle %0d", bus.rsp_id, bus.rsp_data, hs_cyc);
        to_start();
        to_mid();
        checks++;
        if (bus.req_ready !== 4'b0100 || cyc !== hs_cyc + 1) begin
            failures++;
            $display("FAIL bp_next_accept: got ready=%b at +%0d expected 0100 at +1", bus.req_ready, cyc - hs_cyc);
        end
        to_start();
        bus.req_valid = '0;
        to_mid();
        n = 0;
        while (bus.rsp_valid !== 1'b1 && n < 40) begin
            to_start();
            to_mid();
            n++;
        end
        checks++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'd2) begin
            failures++;
            $display("FAIL bp_next_rsp: got valid=%b id=%0d expected 1 2", bus.rsp_valid, bus.rsp_id);
        end
        to_start();
    endtask

    task automatic test_reset_mid_wait();
        int n;
        int s0;
        bus.req_func[2] = 2'b01;
        bus.rsp_ready   = 1'b1;
        core_delay      = -1;
        bus.req_valid   = 4'b0100;
        to_mid();
        checks++;
        if (bus.req_ready !== 4'b0100) begin
            failures++;
            $display("FAIL rst_pre_grant: got %b expected 0100", bus.req_ready);
        end
        to_start();
        bus.req_valid = '0;
        to_mid();
        to_start();
        to_mid();
        to_start();
        reset         = 1'b0;
        bus.req_valid = 4'b1010;
        s0 = start_cnt;
        to_mid();
        checks++;
        if (bus.req_ready !== 4'b0000) begin
            failures++;
            $display("FAIL rst_ready_forced: got %b expected 0000", bus.req_ready);
        end
        to_start();
        reset = 1'b1;
        to_mid();
        checks++;
        if ({bus.rsp_valid, bus.rsp_id, bus.rsp_data, bus.rsp_err, bus.core_start,
             bus.core_func, bus.core_text, bus.core_key, bus.busy} !== '0) begin
            failures++;
            $display("FAIL rst_mid_outputs: got valid=%b busy=%b start=%b func=%b err=%b expected all zero",
                     bus.rsp_valid, bus.busy, bus.core_start, bus.core_func, bus.rsp_err);
        end
        checks++;
        if (bus.req_ready !== 4'b0010) begin
            failures++;
            $display("FAIL rst_ptr_zero_grant: got %b expected 0010", bus.req_ready);
        end
        to_start();
        bus.req_valid = '0;
        checks++;
        if (start_cnt !== s0) begin
            failures++;
            $display("FAIL rst_no_start: got %0d extra starts expected 0", start_cnt - s0);
        end
        to_mid();
        n = 0;
        while (bus.rsp_valid !== 1'b1 && n < 40) begin
            to_start();
            to_mid();
            n++;
        end
        checks++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'd1 || bus.rsp_err !== 1'b1) begin
            failures++;
            $display("FAIL rst_next_rsp: got valid=%b id=%0d err=%b expected 1 1 1", bus.rsp_valid, bus.rsp_id, bus.rsp_err);
        end
        $display("post-reset job id=%0d err=%0d", bus.rsp_id, bus.rsp_err);
        to_start();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.req_valid       = '0;
        bus.req_func        = '0;
        bus.req_text        = '0;
        bus.req_key         = '0;
        bus.core_ciphertext = '0;
        bus.core_plaintext  = '0;
        bus.rsp_ready       = 1'b0;
        test_reset();
        test_single_encrypt();
        test_round_robin();
        test_decrypt_select();
        test_illegal_timeout();
        test_backpressure();
        test_reset_mid_wait();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/aes_job_arbiter.md
# aes_job_arbiter

Shares one `aes_build` core between `NREQ` requesters. Each request carries a function code, a 128-bit text and a 128-bit key. The block round-robin arbitrates among requesters, latches the winning job, sequences it through the core, and bounds each job with a completion timeout. It returns exactly one tagged response per accepted job, with an error flag. It sits between the request sources (DMA/command front-end) and `aes_build`, and drives that core's `func`/`text_in`/`true_key` inputs.

## Interface
Parameters:
- `NREQ`, 4: number of requesters (2..8).
- `TIMEOUT`, 64: maximum cycles spent in WAIT before the job is aborted (≥2).
- `IDW`, `$clog2(NREQ)`: width of the response tag.

Ports:
- `eph1`  in  1  clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-low reset (0 = in reset).
- `req_valid`  in  NREQ  per-requester job valid.
- `req_ready`  out  NREQ  one-hot accept; the job transfers when `req_valid[i] & req_ready[i]`.
- `req_func`  in  NREQ×2  per-requester function code: 01 = encrypt, 10 = decrypt, 11 = encrypt, 00 = illegal.
- `req_text`  in  NREQ×128  per-requester plaintext or ciphertext input.
- `req_key`  in  NREQ×128  per-requester 128-bit key.
- `core_start`  out  1  one-cycle pulse that starts the core.
- `core_func`  out  2  drives the `func` input of `aes_build`.
- `core_text`  out  128  drives the `text_in` input of `aes_build`.
- `core_key`  out  128  drives the `true_key` input of `aes_build`.
- `core_done`  in  1  the `call_complete` output of `aes_build`.
- `core_ciphertext`  in  128  core encrypt result.
- `core_plaintext`  in  128  core decrypt result.
- `rsp_valid`  out  1  response valid.
- `rsp_ready`  in  1  response accept.
- `rsp_id`  out  IDW  index of the requester that owns the response.
- `rsp_data`  out  128  result data.
- `rsp_err`  out  1  1 = illegal function code or timeout.
- `busy`  out  1  high in every state except IDLE.

## Operation
The FSM has four states: IDLE, START, WAIT, RESP.

IDLE:
- `req_ready` is the one-hot grant (combinational) among `req_valid`. The search starts at pointer `ptr` and moves upward, wrapping modulo `NREQ`.
- When a grant occurs, capture the winner's id, func, text and key into the `core_*` registers.
- If func = 00: set `rsp_err` = 1 and `rsp_data` = 0, then go to RESP without starting the core.
- Otherwise go to START.
- If no request is valid, `req_ready` = 0 and the FSM stays in IDLE.

START:
- Assert `core_start` for exactly this cycle.
- Clear the timer to 0.
- Go to WAIT.

WAIT:
- Increment the timer each cycle.
- On `core_done`: set `rsp_data` = `core_func[0]` ? `core_ciphertext` : `core_plaintext`, set `rsp_err` = 0, and go to RESP.
- Otherwise, when timer = `TIMEOUT`-1: set `rsp_err` = 1 and `rsp_data` = 0, and go to RESP.
- If `core_done` and timeout occur in the same cycle, `core_done` wins.

RESP:
- Hold `rsp_valid` = 1. `rsp_id`, `rsp_data` and `rsp_err` stay stable until the handshake.
- On `rsp_ready`: set `ptr` = (`rsp_id`+1) mod `NREQ` and go to IDLE.

General rules:
- `core_func`, `core_text` and `core_key` are registered at accept. They hold through START, WAIT and RESP until the next accept.
- `core_done` is ignored in IDLE, START and RESP.
- `req_ready` is 0 outside IDLE, so at most one job is in flight at a time.

## Timing
Reset (`reset` = 0 at a clock edge):
- State goes to IDLE and `ptr` = 0.
- These outputs are 0: `rsp_valid`, `rsp_id`, `rsp_data`, `rsp_err`, `core_start`, `core_func`, `core_text`, `core_key`, `busy`.
- `req_ready` is forced to 0 while `reset` = 0.
- A reset during any state aborts the job. No response is issued and no further `core_start` pulse occurs.

Job latency:
- Accept at cycle T.
- `core_start` = 1 during T+1.
- WAIT begins at T+2.
- If `core_done` arrives at cycle D, `rsp_valid` rises at D+1.
- An illegal func gives `rsp_valid` at T+1.
- A timeout gives `rsp_valid` at T+2+`TIMEOUT`.

Throughput:
- The earliest next accept is the cycle after the `rsp_valid & rsp_ready` handshake.
- The minimum spacing between successive `core_start` pulses is 4 cycles.

Backpressure:
- If `rsp_ready` = 0, the FSM holds RESP indefinitely. `rsp_*` outputs stay stable and no new job is accepted.

Fairness:
- A requester that holds `req_valid` is granted within `NREQ` jobs.

## Test plan
- **Single encrypt.** Requester 0 sends func = 01, key 000102…0e0f, text 00112233…eeff; the core model raises `core_done` 5 cycles after start.
  - Required: `core_start` at T+1; `rsp_valid` 6 cycles after start; `rsp_id` = 0; `rsp_err` = 0; `rsp_data` = 69c4e0d86a7b0430d8cdb78070b4c55a.
- **Round-robin.** All four requesters hold `req_valid` with `rsp_ready` = 1.
  - Required: grants go in order 0, 1, 2, 3, 0.
  - Then deassert requester 1: the next grants skip it (2, 3, 0, 2…).
- **Decrypt selection.** func = 10 with `core_plaintext` = AA…AA and `core_ciphertext` = 55…55.
  - Required: `rsp_data` = AA…AA.
  - The same job with func = 11 returns 55…55.
- **Illegal code and timeout.**
  - func = 00: `rsp_valid` at T+1, `rsp_err` = 1, no `core_start`.
  - `TIMEOUT` = 8 and `core_done` never asserted: `rsp_err` = 1 and `rsp_data` = 0 at T+10.
  - `core_done` on the timeout cycle: `rsp_err` = 0.
- **Backpressure.** Hold `rsp_ready` = 0 for 20 cycles.
  - Required: `rsp_*` stable, `req_ready` = 0, and a spurious `core_done` pulse is ignored.
  - Release: handshake, then the next accept on the following cycle.
- **Reset mid-WAIT.** Drive `reset` = 0 for 1 cycle.
  - Required: all outputs return to 0 and no response is produced.
  - A request pending after reset is granted from `ptr` = 0.
